demux16_reg: RTL and testbench
==============================

Name: demux16_reg

Overview:
- 1-to-16 registered stream demultiplexer; the distributing counterpart of the 16:1 combinational select mux.
- Accepts one W-bit word per handshake on a single input and steers it by a 4-bit select into one of 16 single-entry output slots.
- Each output slot has its own valid/ready handshake.
- Sits between a shared producer and 16 independent consumers, e.g. fanning a shared bus out to per-lane units.

Parameters:
- W, 1, data width of each word.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- sel  input  4  destination channel for the current input word; only sampled when i_valid=1.
- i_data  input  W  input word.
- i_valid  input  1  input word present.
- i_ready  output  1  input word accepted this cycle when i_valid=1.
- o_data  output  16*W  channel n occupies bits [n*W +: W].
- o_valid  output  16  per-channel slot full.
- o_ready  input  16  per-channel consumer takes the word.
- o_count  output  5  number of full slots, 0..16.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - o_valid=0, o_data=0 for all channels, o_count=0.
  - Asserting reset_n low mid-operation discards all held words immediately.
- Input handshake:
  - i_ready = ~o_valid[sel] | o_ready[sel]. Combinational from sel and o_ready; no dependency on i_valid.
  - Accept = i_valid & i_ready.
- On accept, slot sel loads i_data at the next clock edge and o_valid[sel]=1.
  - Latency is exactly 1 cycle from accept to visibility on o_data/o_valid.
- Drain: o_valid[n] & o_ready[n] clears o_valid[n] at the next edge, unless the same cycle also accepts into n.
- Simultaneous accept and drain on the same channel: slot reloads with the new word and o_valid[n] stays 1. This gives full throughput of 1 word per cycle per channel.
- Stall: while o_valid[n]=1 and o_ready[n]=0, o_data[n] is held bit-stable.
- Drains on other channels proceed in parallel, independent of input traffic; up to 16 drains plus 1 accept can occur in one cycle.
- Data register policy:
  - o_data[n] updates only on accept into n. It is not cleared on drain; it holds its last value while o_valid[n]=0.
  - o_data is don't-care for verification when o_valid[n]=0, except after reset, when it must be 0.
- o_count:
  - Registered; next = count + accept_into_empty_or_draining_slot_net − drains, computed as the popcount of next o_valid.
  - Never exceeds 16 and never underflows.
- No internal state machine beyond per-slot full flags; sel has no effect while i_valid=0.
- o_ready on an empty slot is ignored.

Decomposition:
- Shared package/header: constants N_CH=16 and SEL_W=4, plus a channel-slice helper macro/function for [n*W +: W].
- Sub-module demux_slot (parameter W):
  - Ports: clk, reset_n, load, load_data, o_ready, o_data, o_valid.
  - Behaviour: the single-entry register with load/drain rules above.
- Top instantiates 16 slots in a generate loop, plus the sel decoder, i_ready mux and popcount register.

Test Plan:
- Reset: drive reset_n=0 mid-stream with slots 3 and 9 full -> same cycle o_valid=16'h0000, o_data=0, o_count=0; after release, i_ready=1 for any sel.
- Basic route: sel=4'd5, i_data=8'hA5 (W=8), i_valid=1 for 1 cycle -> next cycle o_valid=16'h0020, o_data[5]=8'hA5, o_count=1; assert o_ready[5] -> o_valid=0, o_count=0.
- Backpressure: fill ch 2 with 8'h11, o_ready[2]=0, then send 8'h22 to sel=2 -> i_ready=0, o_data[2] stays 8'h11; raise o_ready[2] -> i_ready=1 that cycle, next cycle o_data[2]=8'h22, o_valid[2]=1.
- Streaming: o_ready[7]=1 continuously, 8 back-to-back words 0..7 to sel=7 -> one word per cycle on ch 7, o_valid[7] stays 1 throughout, o_count=1.
- Full fan-out: 16 words to sel=0..15 with all o_ready=0 -> o_count reaches 16, o_valid=16'hFFFF; 17th word to sel=0 sees i_ready=0; drop all o_ready=1 in one cycle -> o_count=0.
- Mixed: each cycle, accept into empty ch 4 while draining ch 1 and ch 12 -> o_count decreases by exactly 1; randomized run checks scoreboard order per channel and o_count == popcount(o_valid).

Source files
------------

// File: rtl/demux16_reg_pkg.sv
// Shared constants and helpers for the 16-way registered demultiplexer.
// Channel geometry, slice offset helper and full-slot popcount.
package demux16_reg_pkg;

    localparam int N_CH  = 16;
    localparam int SEL_W = 4;
    localparam int CNT_W = 5;

    // Bit offset of channel n inside the packed o_data bus.
    function automatic int ch_lsb(input int n, input int w);
        return n * w;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [N_CH-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt = cnt + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/demux16_reg_if.sv
// Producer-side input handshake plus the 16 per-channel output handshakes.
// The slave modport faces the demux; the master modport faces producer and consumers.
interface demux16_reg_if #(parameter int W = 1);
    import demux16_reg_pkg::*;

    logic [SEL_W-1:0]  sel;
    logic [W-1:0]      i_data;
    logic              i_valid;
    logic              i_ready;
    logic [N_CH*W-1:0] o_data;
    logic [N_CH-1:0]   o_valid;
    logic [N_CH-1:0]   o_ready;
    logic [CNT_W-1:0]  o_count;

    modport master (
        output sel, i_data, i_valid, o_ready,
        input  i_ready, o_data, o_valid, o_count
    );

    modport slave (
        input  sel, i_data, i_valid, o_ready,
        output i_ready, o_data, o_valid, o_count
    );

endinterface

// File: rtl/demux16_reg_slot.sv
// Single-entry output slot: loads on accept, clears on drain, reload wins over drain.
// Latency 1 cycle load-to-visible; data held bit-stable while full and not drained.
module demux_slot #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid
);

    logic [W-1:0] data_d, data_q;
    logic         valid_d, valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (valid_q && o_ready) begin
            valid_d = 1'b0;
        end
        // Data is not cleared on drain; only a new load changes it.
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

endmodule

// File: rtl/demux16_reg.sv
// 1-to-16 registered stream demux: steers each accepted word into slot[sel], 1-cycle latency.
// i_ready = slot[sel] empty or draining this cycle; drains on all channels run in parallel.
module demux16_reg
    import demux16_reg_pkg::*;
#(
    parameter int W = 1
) (
    input logic           clk,
    input logic           reset_n,
    demux16_reg_if.slave  bus
);

    logic [N_CH-1:0]   load;
    logic [N_CH-1:0]   valid;
    logic [N_CH-1:0]   valid_nxt;
    logic [N_CH*W-1:0] data_all;
    logic              i_ready;
    logic              accept;
    logic [CNT_W-1:0]  count_d, count_q;

    always_comb begin
        i_ready = ~valid[bus.sel] | bus.o_ready[bus.sel];
        accept  = bus.i_valid & i_ready;
        load    = '0;
        if (accept) begin
            load[bus.sel] = 1'b1;
        end
        // Mirrors the slot update rule so the count is exact in the same cycle.
        valid_nxt = load | (valid & ~bus.o_ready);
        count_d   = popcount(valid_nxt);
    end

    for (genvar n = 0; n < N_CH; n++) begin : g_slot
        localparam int LSB = ch_lsb(n, W);

        demux_slot #(.W(W)) u_slot (
            .clk       (clk),
            .reset_n   (reset_n),
            .load      (load[n]),
            .load_data (bus.i_data),
            .o_ready   (bus.o_ready[n]),
            .o_data    (data_all[LSB +: W]),
            .o_valid   (valid[n])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.i_ready = i_ready;
    assign bus.o_data  = data_all;
    assign bus.o_valid = valid;
    assign bus.o_count = count_q;

endmodule

// File: tb/tb_demux16_reg.sv
// Directed and scoreboard-checked stimulus for demux16_reg with W=8.
module tb_demux16_reg;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]   sbq [16][$];
    logic [127:0] exp_data;
    logic [15:0]  mv;
    int           total;
    logic         exp_rdy;

    always #5 clk = ~clk;

    demux16_reg_if #(.W(8)) bus ();

    demux16_reg #(.W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] od(input int n);
        return bus.o_data[n*8 +: 8];
    endfunction

    initial begin
        reset_n     = 1'b0;
        bus.sel     = 4'd0;
        bus.i_data  = 8'h00;
        bus.i_valid = 1'b0;
        bus.o_ready = 16'h0000;
        step();
        step();
        chk("rst_valid", 128'(bus.o_valid), 128'(16'h0000));
        chk("rst_count", 128'(bus.o_count), 128'(5'd0));
        chk("rst_data",  bus.o_data, 128'd0);
        reset_n = 1'b1;
        step();

        // Basic route to channel 5
        bus.sel = 4'd5; bus.i_data = 8'hA5; bus.i_valid = 1'b1;
        #1 chk("basic_irdy", 128'(bus.i_ready), 128'(1'b1));
        step();
        bus.i_valid = 1'b0;
        chk("basic_valid", 128'(bus.o_valid), 128'(16'h0020));
        chk("basic_data",  128'(od(5)), 128'(8'hA5));
        chk("basic_count", 128'(bus.o_count), 128'(5'd1));
        bus.o_ready[5] = 1'b1;
        step();
        bus.o_ready = 16'h0000;
        chk("drain_valid", 128'(bus.o_valid), 128'(16'h0000));
        chk("drain_count", 128'(bus.o_count), 128'(5'd0));

        // Backpressure on channel 2
        bus.sel = 4'd2; bus.i_data = 8'h11; bus.i_valid = 1'b1;
        step();
        bus.i_data = 8'h22;
        #1 chk("bp_irdy_low", 128'(bus.i_ready), 128'(1'b0));
        step();
        chk("bp_hold_data",  128'(od(2)), 128'(8'h11));
        chk("bp_hold_valid", 128'(bus.o_valid), 128'(16'h0004));
        bus.o_ready[2] = 1'b1;
        #1 chk("bp_irdy_high", 128'(bus.i_ready), 128'(1'b1));
        step();
        bus.i_valid = 1'b0;
        bus.o_ready = 16'h0000;
        chk("bp_reload_data",  128'(od(2)), 128'(8'h22));
        chk("bp_reload_valid", 128'(bus.o_valid), 128'(16'h0004));
        chk("bp_reload_count", 128'(bus.o_count), 128'(5'd1));
        bus.o_ready[2] = 1'b1;
        step();
        bus.o_ready = 16'h0000;
        chk("bp_empty_count", 128'(bus.o_count), 128'(5'd0));

        // Streaming on channel 7 at one word per cycle
        bus.o_ready[7] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.sel = 4'd7; bus.i_data = 8'(k); bus.i_valid = 1'b1;
            #1 chk("stream_irdy", 128'(bus.i_ready), 128'(1'b1));
            step();
            chk("stream_valid", 128'(bus.o_valid), 128'(16'h0080));
            chk("stream_data",  128'(od(7)), 128'(k));
            chk("stream_count", 128'(bus.o_count), 128'(5'd1));
        end
        bus.i_valid = 1'b0;
        step();
        bus.o_ready = 16'h0000;
        chk("stream_end_valid", 128'(bus.o_valid), 128'(16'h0000));

        // Full fan-out
        exp_data = '0;
        for (int k = 0; k < 16; k++) begin
            bus.sel = 4'(k); bus.i_data = 8'(8'h30 + k); bus.i_valid = 1'b1;
            exp_data[k*8 +: 8] = 8'(8'h30 + k);
            step();
        end
        bus.i_valid = 1'b0;
        chk("full_valid", 128'(bus.o_valid), 128'(16'hFFFF));
        chk("full_count", 128'(bus.o_count), 128'(5'd16));
        chk("full_data",  bus.o_data, exp_data);
        bus.sel = 4'd0; bus.i_data = 8'hEE; bus.i_valid = 1'b1;
        #1 chk("full_irdy_low", 128'(bus.i_ready), 128'(1'b0));
        step();
        bus.i_valid = 1'b0;
        chk("full_no_overwrite", 128'(od(0)), 128'(8'h30));
        chk("full_count_hold",   128'(bus.o_count), 128'(5'd16));

        // Mixed: free ch4, then refill it while draining ch1 and ch12
        bus.o_ready = 16'h0010;
        step();
        chk("mixed_count_a", 128'(bus.o_count), 128'(5'd15));
        bus.o_ready = 16'h1002;
        bus.sel = 4'd4; bus.i_data = 8'h44; bus.i_valid = 1'b1;
        #1 chk("mixed_irdy", 128'(bus.i_ready), 128'(1'b1));
        step();
        bus.i_valid = 1'b0;
        bus.o_ready = 16'h0000;
        chk("mixed_count_b", 128'(bus.o_count), 128'(5'd14));
        chk("mixed_valid",   128'(bus.o_valid), 128'(16'hEFFD));
        chk("mixed_data4",   128'(od(4)), 128'(8'h44));
        bus.o_ready = 16'hFFFF;
        step();
        chk("all_drain_count", 128'(bus.o_count), 128'(5'd0));
        step();
        bus.o_ready = 16'h0000;
        chk("empty_ready_ignored", 128'(bus.o_count), 128'(5'd0));

        // Reset mid-stream with slots 3 and 9 full
        bus.sel = 4'd3; bus.i_data = 8'h33; bus.i_valid = 1'b1;
        step();
        bus.sel = 4'd9; bus.i_data = 8'h99;
        step();
        bus.i_valid = 1'b0;
        chk("pre_rst_valid", 128'(bus.o_valid), 128'(16'h0208));
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 128'(bus.o_valid), 128'(16'h0000));
        chk("async_rst_count", 128'(bus.o_count), 128'(5'd0));
        chk("async_rst_data",  bus.o_data, 128'd0);
        step();
        reset_n = 1'b1;
        step();
        for (int k = 0; k < 16; k++) begin
            bus.sel = 4'(k);
            #1 chk("post_rst_irdy", 128'(bus.i_ready), 128'(1'b1));
        end

        // Random traffic against per-channel scoreboard queues
        for (int cyc = 0; cyc < 300; cyc++) begin
            mv = '0;
            total = 0;
            for (int n = 0; n < 16; n++) begin
                mv[n] = (sbq[n].size() != 0);
                total += sbq[n].size();
            end
            chk("rnd_valid", 128'(bus.o_valid), 128'(mv));
            chk("rnd_count", 128'(bus.o_count), 128'(total));
            bus.o_ready = 16'($urandom) & 16'($urandom);
            bus.sel     = 4'($urandom_range(15));
            bus.i_data  = 8'($urandom);
            bus.i_valid = ($urandom_range(3) != 0);
            #1;
            exp_rdy = (sbq[bus.sel].size() == 0) || bus.o_ready[bus.sel];
            chk("rnd_irdy", 128'(bus.i_ready), 128'(exp_rdy));
            for (int n = 0; n < 16; n++) begin
                if (sbq[n].size() != 0 && bus.o_ready[n]) begin
                    chk("rnd_drain_data", 128'(od(n)), 128'(sbq[n][0]));
                    void'(sbq[n].pop_front());
                end
            end
            if (bus.i_valid && exp_rdy) begin
                sbq[bus.sel].push_back(bus.i_data);
            end
            step();
        end
        bus.i_valid = 1'b0;
        bus.o_ready = 16'h0000;
        total = 0;
        for (int n = 0; n < 16; n++) total += sbq[n].size();
        chk("rnd_final_count", 128'(bus.o_count), 128'(total));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
